// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_datapath
// Description : Arithmetic datapath driven by the multicycle control unit.
//               Holds operands A..D and an accumulator, applies one add or
//               subtract step per enabled cycle, latches the final result on
//               the rising edge of done and flags control-sequence protocol
//               violations. Define MCDP_OVERFLOW_EN to add the sticky signed
//               overflow flag and its output port.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ld_operands,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic             e,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             add_or_sub,
    input  logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic [2:0]       step_count,
    output logic             proto_err
`ifdef MCDP_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam logic [2:0] c_COUNT_MAX  = 3'd7;
    localparam logic [2:0] c_COUNT_GOOD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_acc;
    logic             r_done_prev;

    logic             w_done_rise;
    logic [WIDTH-1:0] w_a_eff;
    logic [WIDTH-1:0] w_operand;
    logic             w_sel_valid;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_acc_step;
    logic [2:0]       w_count_inc;
    logic [WIDTH-1:0] w_acc_next;
    logic [2:0]       w_count_next;
    logic             w_err_next;
`ifdef MCDP_OVERFLOW_EN
    logic             r_overflow;
    logic             w_step_ovf;
    logic             w_ovf_next;
`endif

    // Operand selection, step arithmetic and next-state values for ACCUM
    always_comb begin
        w_done_rise = done & ~r_done_prev;
        // Write-through so a load step in the capture cycle sees the new A
        w_a_eff     = ld_operands ? a_in : r_a;
        w_sel_valid = ~(s2 & s1);
        case ({s2, s1})
            2'b00:   w_operand = r_b;
            2'b01:   w_operand = r_c;
            2'b10:   w_operand = r_d;
            default: w_operand = '0;
        endcase
        w_sum       = r_acc + w_operand;
        w_diff      = r_acc - w_operand;
        w_acc_step  = add_or_sub ? w_sum : w_diff;
        w_count_inc = (step_count == c_COUNT_MAX) ? c_COUNT_MAX : step_count + 3'd1;
`ifdef MCDP_OVERFLOW_EN
        if (add_or_sub)
            w_step_ovf = (r_acc[WIDTH-1] == w_operand[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
        else
            w_step_ovf = (r_acc[WIDTH-1] != w_operand[WIDTH-1]) &&
                         (w_diff[WIDTH-1] != r_acc[WIDTH-1]);
        w_ovf_next = r_overflow;
`endif

        w_acc_next   = r_acc;
        w_count_next = step_count;
        w_err_next   = proto_err;
        if (e) begin
            if (!s0) begin
                // Load step mid-sequence: restart from A, but flag it
                w_acc_next   = r_a;
                w_count_next = 3'd1;
                w_err_next   = 1'b1;
`ifdef MCDP_OVERFLOW_EN
                w_ovf_next   = 1'b0;
`endif
            end else begin
                w_count_next = w_count_inc;
                if (w_sel_valid) begin
                    w_acc_next = w_acc_step;
`ifdef MCDP_OVERFLOW_EN
                    w_ovf_next = r_overflow | w_step_ovf;
`endif
                end else begin
                    w_err_next = 1'b1;
                end
            end
        end
        // A well-formed sequence is exactly load plus three accumulate steps
        if (w_done_rise && (w_count_next != c_COUNT_GOOD))
            w_err_next = 1'b1;
    end

    // Control FSM with registered datapath and outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_d          <= '0;
            r_acc        <= '0;
            r_done_prev  <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            step_count   <= 3'd0;
            proto_err    <= 1'b0;
`ifdef MCDP_OVERFLOW_EN
            r_overflow   <= 1'b0;
`endif
        end else begin
            r_done_prev  <= done;
            result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ld_operands) begin
                        r_a <= a_in;
                        r_b <= b_in;
                        r_c <= c_in;
                        r_d <= d_in;
                    end
                    if (e) begin
                        if (!s0) begin
                            r_acc      <= w_a_eff;
                            step_count <= 3'd1;
                            proto_err  <= 1'b0;
`ifdef MCDP_OVERFLOW_EN
                            r_overflow <= 1'b0;
`endif
                            busy       <= 1'b1;
                            r_state    <= ST_ACCUM;
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    r_acc      <= w_acc_next;
                    step_count <= w_count_next;
                    proto_err  <= w_err_next;
`ifdef MCDP_OVERFLOW_EN
                    r_overflow <= w_ovf_next;
`endif
                    if (w_done_rise) begin
                        result       <= w_acc_next;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        r_state      <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MCDP_OVERFLOW_EN
    assign overflow = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_datapath
// Description : Self-checking bench for multicycle_datapath. Expected results
//               are queued when done is driven and compared when result_valid
//               appears. Honours MCDP_OVERFLOW_EN for the overflow port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_datapath;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             ld_operands;
    logic [WIDTH-1:0] a_in, b_in, c_in, d_in;
    logic             e, s0, s1, s2, add_or_sub, done;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             busy;
    logic [2:0]       step_count;
    logic             proto_err;
`ifdef MCDP_OVERFLOW_EN
    logic             overflow;
`endif

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];

    multicycle_datapath #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .ld_operands  (ld_operands),
        .a_in         (a_in),
        .b_in         (b_in),
        .c_in         (c_in),
        .d_in         (d_in),
        .e            (e),
        .s0           (s0),
        .s1           (s1),
        .s2           (s2),
        .add_or_sub   (add_or_sub),
        .done         (done),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .step_count   (step_count),
        .proto_err    (proto_err)
`ifdef MCDP_OVERFLOW_EN
        ,
        .overflow     (overflow)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of controller outputs
    task automatic cyc(input logic ie, input logic is0, input logic [1:0] sel,
                       input logic iadd, input logic idone);
        e          = ie;
        s0         = is0;
        {s2, s1}   = sel;
        add_or_sub = iadd;
        done       = idone;
        tick();
    endtask

    // Wait (bounded) for result_valid and compare against the scoreboard
    task automatic wait_result(input string tag);
        logic [WIDTH-1:0] exp;
        int n = 0;
        while (!result_valid && n < 5) begin
            tick();
            n++;
        end
        if (result_valid && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk(tag, 32'(result), 32'(exp));
        end else begin
            chk({tag, "_timeout"}, 32'(result_valid), 32'd1);
        end
    endtask

    task automatic load_ops(input logic [WIDTH-1:0] a, b, c, d);
        a_in = a; b_in = b; c_in = c; d_in = d;
        ld_operands = 1'b1;
        cyc(0, 0, 2'b00, 0, 0);
        ld_operands = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ld_operands = 1'b0;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0;
        e = 0; s0 = 0; s1 = 0; s2 = 0; add_or_sub = 0; done = 0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_result", 32'(result), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(step_count), 0);
        chk("rst_err", 32'(proto_err), 0);

        load_ops(8'd10, 8'd5, 8'd3, 8'd2);

        // Accumulate step while idle is a protocol error
        cyc(1, 1, 2'b00, 1, 0);
        chk("idle_acc_err", 32'(proto_err), 1);
        chk("idle_acc_busy", 32'(busy), 0);
        chk("idle_acc_count", 32'(step_count), 0);

        // Done rise while idle is ignored
        cyc(0, 0, 2'b00, 0, 1);
        chk("idle_done_valid", 32'(result_valid), 0);
        cyc(0, 0, 2'b00, 0, 0);
        chk("idle_done_valid2", 32'(result_valid), 0);

        // Mode 0: A+B+C-D = 16
        cyc(1, 0, 2'b00, 0, 0);
        chk("m0_load_err", 32'(proto_err), 0);
        chk("m0_load_busy", 32'(busy), 1);
        chk("m0_load_count", 32'(step_count), 1);
        cyc(1, 1, 2'b00, 1, 0);
        cyc(1, 1, 2'b01, 1, 0);
        cyc(1, 1, 2'b10, 0, 0);
        chk("m0_count", 32'(step_count), 4);
        exp_q.push_back(8'd16);
        cyc(0, 0, 2'b00, 0, 1);
        wait_result("m0_result");
        chk("m0_err", 32'(proto_err), 0);
        chk("m0_final_count", 32'(step_count), 4);
        chk("m0_busy_result", 32'(busy), 0);
        cyc(0, 0, 2'b00, 0, 0);
        chk("m0_pulse_end", 32'(result_valid), 0);
        chk("m0_result_hold", 32'(result), 16);
`ifdef MCDP_OVERFLOW_EN
        chk("m0_overflow", 32'(overflow), 0);
`endif

        // Mode 1: A-B+C+D = 10; operand load mid-sequence must be ignored
        cyc(1, 0, 2'b00, 0, 0);
        cyc(1, 1, 2'b00, 0, 0);
        ld_operands = 1'b1; d_in = 8'd50;
        cyc(1, 1, 2'b01, 1, 0);
        ld_operands = 1'b0; d_in = 8'd2;
        cyc(1, 1, 2'b10, 1, 0);
        exp_q.push_back(8'd10);
        cyc(0, 0, 2'b00, 0, 1);
        wait_result("m1_result");
        chk("m1_err", 32'(proto_err), 0);
        cyc(0, 0, 2'b00, 0, 0);

        // Illegal select leaves acc alone: 10+5-2 = 13, error sticks
        cyc(1, 0, 2'b00, 0, 0);
        cyc(1, 1, 2'b00, 1, 0);
        cyc(1, 1, 2'b11, 1, 0);
        chk("ill_err", 32'(proto_err), 1);
        chk("ill_count", 32'(step_count), 3);
        cyc(1, 1, 2'b10, 0, 0);
        exp_q.push_back(8'd13);
        cyc(0, 0, 2'b00, 0, 1);
        wait_result("ill_result");
        chk("ill_err_done", 32'(proto_err), 1);
        cyc(0, 0, 2'b00, 0, 0);
        chk("ill_err_idle", 32'(proto_err), 1);

        // Next load clears it; final step coincides with the done rise
        cyc(1, 0, 2'b00, 0, 0);
        chk("ill_err_cleared", 32'(proto_err), 0);
        cyc(1, 1, 2'b00, 1, 0);
        cyc(1, 1, 2'b01, 1, 0);
        exp_q.push_back(8'd16);
        cyc(1, 1, 2'b10, 0, 1);
        wait_result("same_cyc_result");
        chk("same_cyc_count", 32'(step_count), 4);
        chk("same_cyc_err", 32'(proto_err), 0);
        cyc(0, 0, 2'b00, 0, 0);

        // Step counter saturates at 7; wrong count flags an error
        cyc(1, 0, 2'b00, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 2'b00, 1, 0);
        chk("sat_count", 32'(step_count), 7);
        exp_q.push_back(8'd50);
        cyc(0, 0, 2'b00, 0, 1);
        wait_result("sat_result");
        chk("sat_err", 32'(proto_err), 1);
        cyc(0, 0, 2'b00, 0, 0);

        // Reset mid-sequence
        cyc(1, 0, 2'b00, 0, 0);
        cyc(1, 1, 2'b11, 1, 0);
        cyc(1, 1, 2'b00, 1, 0);
        reset = 1'b1;
        cyc(0, 0, 2'b00, 0, 0);
        reset = 1'b0;
        chk("mid_rst_result", 32'(result), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_count", 32'(step_count), 0);
        chk("mid_rst_err", 32'(proto_err), 0);
        chk("mid_rst_valid", 32'(result_valid), 0);

        // Capture and load step in one cycle (write-through), then mode 0
        a_in = 8'd10; b_in = 8'd5; c_in = 8'd3; d_in = 8'd2;
        ld_operands = 1'b1;
        cyc(1, 0, 2'b00, 0, 0);
        ld_operands = 1'b0;
        cyc(1, 1, 2'b00, 1, 0);
        cyc(1, 1, 2'b01, 1, 0);
        cyc(1, 1, 2'b10, 0, 0);
        exp_q.push_back(8'd16);
        cyc(0, 0, 2'b00, 0, 1);
        wait_result("post_rst_result");
        cyc(0, 0, 2'b00, 0, 0);

        // Signed overflow: 100 + 50 wraps to 150 (-106)
        a_in = 8'd100; b_in = 8'd50; c_in = 8'd0; d_in = 8'd0;
        ld_operands = 1'b1;
        cyc(1, 0, 2'b00, 0, 0);
        ld_operands = 1'b0;
        cyc(1, 1, 2'b00, 1, 0);
        cyc(1, 1, 2'b01, 1, 0);
        cyc(1, 1, 2'b10, 0, 0);
        exp_q.push_back(8'd150);
        cyc(0, 0, 2'b00, 0, 1);
        wait_result("ovf_result");
        chk("ovf_err", 32'(proto_err), 0);
`ifdef MCDP_OVERFLOW_EN
        chk("ovf_flag", 32'(overflow), 1);
`endif
        cyc(0, 0, 2'b00, 0, 0);
`ifdef MCDP_OVERFLOW_EN
        chk("ovf_flag_idle", 32'(overflow), 1);
        cyc(1, 0, 2'b00, 0, 0);
        chk("ovf_cleared", 32'(overflow), 0);
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
